sd_block_write_ctrl: RTL
========================

# sd_block_write_ctrl

Sequencer for one SD-card single-block write (CMD24) in SPI mode. It sits between the write buffer (512-byte RAM filled by the byte-capture logic) and the byte-level SPI transceiver, and issues the command, token, payload, CRC and polling bytes in order. It checks the card responses and reports completion or a coded error to the upper layer.

## Interface
- `BLOCK_BYTES`, 512: payload bytes per block.
- `ADDR_W`, 9: buffer address width; must satisfy 2^ADDR_W ≥ BLOCK_BYTES.
- `R1_POLL`, 8: maximum 0xFF polls while waiting for the R1 response.
- `BUSY_POLL`, 65535: maximum 0xFF polls while the card signals busy.
- Clock and reset (already decided): reset reset, synchronous, active-high; clock clk.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a block write; sampled only in IDLE.
- `block_addr` in 32: card block address; latched when `start` is accepted.
- `busy` out 1: high from the cycle after `start` is accepted until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse at the end of every operation, success or error.
- `err` out 1: valid with `done`; held until the next accepted `start`.
- `err_code` out 3: 0 ok, 1 R1 timeout, 2 R1 nonzero, 3 data rejected, 4 busy timeout; held like `err`.
- `cs_n` out 1: card chip select, active low.
- `spi_start` out 1: one-cycle pulse; transceiver sends `spi_tx`.
- `spi_tx` out 8: byte to send; valid in the `spi_start` cycle.
- `spi_done` in 1: one-cycle pulse; byte exchange complete.
- `spi_rx` in 8: received byte; valid in the `spi_done` cycle.
- `buf_addr` out ADDR_W: buffer read address.
- `buf_data` in 8: buffer read data; registered, valid 1 cycle after `buf_addr`.

## Operation
- **Reset values:** `busy`=0, `done`=0, `err`=0, `err_code`=0, `cs_n`=1, `spi_start`=0, `spi_tx`=0xFF, `buf_addr`=0. The state is IDLE and all counters are 0.
- **Byte protocol:** at most one byte is outstanding. Every state issues exactly one `spi_start` and then waits for `spi_done` before it evaluates `spi_rx` or issues the next byte.
- **States:**
  - **IDLE:** on `start`, latch `block_addr`, clear `err`/`err_code`, go to CMD. `start` is ignored in all other states.
  - **CMD:** 6 bytes in this order: 0x58, `addr[31:24]`, `addr[23:16]`, `addr[15:8]`, `addr[7:0]`, 0xFF. Then go to R1.
  - **R1:** send 0xFF.
    - `spi_rx`=0xFF: poll again. After `R1_POLL` 0xFF responses, error 1.
    - `spi_rx`=0x00: go to GAP.
    - Any other value: error 2.
  - **GAP:** one 0xFF byte.
  - **TOKEN:** one 0xFE byte. `buf_addr`=0 is driven on entry.
  - **DATA:** `BLOCK_BYTES` bytes with `spi_tx`=`buf_data`.
    - `buf_addr` increments in the cycle after each `spi_start`, so the next byte is ready.
    - The byte counter runs 0..BLOCK_BYTES-1. `buf_addr` does not wrap past BLOCK_BYTES-1 and holds there.
  - **CRC:** two 0xFF bytes.
  - **DRESP:** one 0xFF byte. `spi_rx[4:0]`==5'b00101 goes to BUSY; anything else is error 3.
  - **BUSY:** send 0xFF until `spi_rx`==0xFF, then go to FINISH. After `BUSY_POLL` non-0xFF responses, error 4.
  - **FINISH:** `cs_n`=1, `done`=1, `busy`=1 for this cycle, then IDLE.
- **Error path:** latch `err`=1 and `err_code`, then go to FINISH. There is no retry.
- **Poll counters:** width is ceil(log2(max+1)). Each counter clears on entry to its state.
- **Reset mid-operation:** return to IDLE with reset values the following cycle. `cs_n` rises immediately; no `done` is issued. A late `spi_done` in IDLE is ignored.

## Timing
- `start` accepted at cycle T: at T+1 `cs_n`=0, `busy`=1, state CMD. First `spi_start` at T+1.
- The next `spi_start` comes exactly 1 cycle after each `spi_done` (one-cycle turnaround), including across state changes.
- DATA bytes: `spi_tx` equals buffer[k] for the k-th data byte, k=0..BLOCK_BYTES-1.
- `done` comes 1 cycle after the `spi_done` that ends BUSY, or after the failing response.
- `cs_n` rises in the `done` cycle. `busy` falls the cycle after `done`.
- A `start` asserted in the `done` cycle is ignored. A `start` in the cycle after `done` is accepted.
- Minimum byte count on success with a zero-wait card: 6+1+1+1+512+2+1+1 = 525 `spi_start` pulses.

## Test plan
- **Nominal write:** buffer[k]=k[7:0], `block_addr`=0x00001234, card returns R1=0x00 on poll 2, DRESP=0xE5, busy 3 polls. Required: bytes 58 00 00 12 34 FF, then FE, then 00..FF twice, then FF FF. `done` with `err`=0, 528 `spi_start` total.
- **R1 timeout:** card returns 0xFF forever. Required: 8 R1 polls, then `done`, `err`=1, `err_code`=1, `cs_n`=1.
- **R1 error:** R1=0x04. Required: no 0xFE token sent, `err_code`=2.
- **Data rejected:** DRESP=0xEB. Required: `err_code`=3 and no BUSY polls.
- **Busy timeout:** with `BUSY_POLL`=16, card returns 0x00 forever. Required: exactly 16 busy polls, `err_code`=4.
- **Reset mid-DATA:** reset at data byte 100. Required: next cycle `cs_n`=1, `busy`=0, no `done`. A new `start` then completes a full nominal write with `buf_addr` beginning at 0.

Source files
------------

// File: rtl/sd_block_write_ctrl.sv
// SPI-mode single-block write (CMD24) sequencer: streams command, token,
// buffered payload, CRC and polling bytes through a byte-level SPI transceiver.
module sd_block_write_ctrl #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned R1_POLL     = 8,
    parameter int unsigned BUSY_POLL   = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       block_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic              cs_n,
    output logic              spi_start,
    output logic [7:0]        spi_tx,
    input  logic              spi_done,
    input  logic [7:0]        spi_rx,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_data
);
    localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned R1_W  = $clog2(R1_POLL + 1);
    localparam int unsigned BSY_W = $clog2(BUSY_POLL + 1);

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_R1_TMO   = 3'd1;
    localparam logic [2:0] ERR_R1_BAD   = 3'd2;
    localparam logic [2:0] ERR_REJECT   = 3'd3;
    localparam logic [2:0] ERR_BUSY_TMO = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC, S_DRESP, S_BUSY, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [R1_W-1:0]    r1_cnt_q, r1_cnt_d;
    logic [BSY_W-1:0]   bsy_cnt_q, bsy_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [2:0]         err_code_q, err_code_d;
    logic               cs_n_q, cs_n_d;
    logic               spi_start_q, spi_start_d;
    logic [7:0]         spi_tx_q, spi_tx_d;
    logic [ADDR_W-1:0]  buf_addr_q, buf_addr_d;

    logic               issue;
    logic [7:0]         issue_byte;
    logic               fin;
    logic [2:0]         fin_code;
    logic [CNT_W-1:0]   cnt_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            r1_cnt_q    <= '0;
            bsy_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_OK;
            cs_n_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_tx_q    <= 8'hFF;
            buf_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            r1_cnt_q    <= r1_cnt_d;
            bsy_cnt_q   <= bsy_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cs_n_q      <= cs_n_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
            buf_addr_q  <= buf_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        r1_cnt_d    = r1_cnt_q;
        bsy_cnt_d   = bsy_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;
        cs_n_d      = cs_n_q;
        spi_start_d = 1'b0;
        spi_tx_d    = spi_tx_q;
        buf_addr_d  = buf_addr_q;
        issue       = 1'b0;
        issue_byte  = 8'hFF;
        fin         = 1'b0;
        fin_code    = ERR_OK;
        cnt_inc     = cnt_q + CNT_W'(1);

        // Prefetch the next payload byte; saturate at the last buffer entry.
        if (state_q == S_DATA && spi_start_q && buf_addr_q != ADDR_W'(BLOCK_BYTES - 1)) begin
            buf_addr_d = buf_addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = block_addr;
                    err_d      = 1'b0;
                    err_code_d = ERR_OK;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_CMD;
                    issue      = 1'b1;
                    issue_byte = 8'h58;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                if (pend_q && spi_done) begin
                    pend_d = 1'b0;
                    case (state_q)
                        S_CMD: begin
                            issue = 1'b1;
                            if (cnt_q == CNT_W'(5)) begin
                                r1_cnt_d = '0;
                                state_d  = S_R1;
                            end else begin
                                cnt_d = cnt_inc;
                                case (cnt_inc)
                                    CNT_W'(1): issue_byte = addr_q[31:24];
                                    CNT_W'(2): issue_byte = addr_q[23:16];
                                    CNT_W'(3): issue_byte = addr_q[15:8];
                                    CNT_W'(4): issue_byte = addr_q[7:0];
                                    default:   issue_byte = 8'hFF;
                                endcase
                            end
                        end
                        S_R1: begin
                            if (spi_rx == 8'hFF) begin
                                if (r1_cnt_q == R1_W'(R1_POLL - 1)) begin
                                    fin      = 1'b1;
                                    fin_code = ERR_R1_TMO;
                                end else begin
                                    r1_cnt_d = r1_cnt_q + R1_W'(1);
                                    issue    = 1'b1;
                                end
                            end else if (spi_rx == 8'h00) begin
                                state_d = S_GAP;
                                issue   = 1'b1;
                            end else begin
                                fin      = 1'b1;
                                fin_code = ERR_R1_BAD;
                            end
                        end
                        S_GAP: begin
                            state_d    = S_TOKEN;
                            buf_addr_d = '0;
                            issue      = 1'b1;
                            issue_byte = 8'hFE;
                        end
                        S_TOKEN: begin
                            cnt_d      = '0;
                            state_d    = S_DATA;
                            issue      = 1'b1;
                            issue_byte = buf_data;
                        end
                        S_DATA: begin
                            issue = 1'b1;
                            if (cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin
                                cnt_d   = '0;
                                state_d = S_CRC;
                            end else begin
                                cnt_d      = cnt_inc;
                                issue_byte = buf_data;
                            end
                        end
                        S_CRC: begin
                            issue = 1'b1;
                            if (cnt_q == CNT_W'(1)) begin
                                state_d = S_DRESP;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                        S_DRESP: begin
                            if (spi_rx[4:0] == 5'b00101) begin
                                bsy_cnt_d = '0;
                                state_d   = S_BUSY;
                                issue     = 1'b1;
                            end else begin
                                fin      = 1'b1;
                                fin_code = ERR_REJECT;
                            end
                        end
                        S_BUSY: begin
                            if (spi_rx == 8'hFF) begin
                                fin = 1'b1;
                            end else if (bsy_cnt_q == BSY_W'(BUSY_POLL - 1)) begin
                                fin      = 1'b1;
                                fin_code = ERR_BUSY_TMO;
                            end else begin
                                bsy_cnt_d = bsy_cnt_q + BSY_W'(1);
                                issue     = 1'b1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase

        if (issue) begin
            spi_start_d = 1'b1;
            spi_tx_d    = issue_byte;
            pend_d      = 1'b1;
        end
        if (fin) begin
            state_d    = S_FINISH;
            done_d     = 1'b1;
            cs_n_d     = 1'b1;
            err_d      = (fin_code != ERR_OK);
            err_code_d = fin_code;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign cs_n      = cs_n_q;
    assign spi_start = spi_start_q;
    assign spi_tx    = spi_tx_q;
    assign buf_addr  = buf_addr_q;

endmodule
